// File: rtl/uart_sched_pkg.sv
`default_nettype none
// uart_sched_pkg: scheduler state encoding, baud-selector width and the round-robin pick helper.
// Revision: 1.0
package uart_sched_pkg;

  localparam int SEL_W     = 2;
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  // One-hot grant of the first set request at or above ptr, wrapping at n (n need not be a power of two).
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          n
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) begin
        idx = idx - n;
      end
      if (!found && (i < n) && req[idx[MAX_IDX_W-1:0]]) begin
        gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational round-robin pick over NUM_REQ requests with a registered priority pointer.
// Revision: 1.0
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  assign pick        = rr_pick(MAX_REQ'(req), MAX_IDX_W'(ptr_q), $unsigned(NUM_REQ));
  assign gnt         = pick[NUM_REQ-1:0];
  assign unused_pick = ^pick;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDX_W'(i);
      end
    end
  end

  // Explicit compare so the wrap is correct when NUM_REQ is not a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// uart_tx_sched: round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Revision: 1.0
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int BUSY_TIMEOUT = 16,
  parameter  int CNT_W        = 16,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [SEL_W-1:0]     cfg_sel,
  output logic [SEL_W-1:0]     sel,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 sched_busy,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     sent_cnt
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [TO_W-1:0]    to_inc;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   sent_q, sent_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               transfer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (transfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are only offered while idle with the transmitter free.
  assign req_ready   = (reset && (state_q == IDLE) && !tx_busy) ? gnt : '0;
  assign transfer    = |(req_ready & req_valid);
  assign tx_start    = (state_q == LAUNCH);
  assign sched_busy  = (state_q != IDLE);
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign sel         = sel_q;
  assign err_timeout = err_q;
  assign sent_cnt    = sent_q;
  assign to_inc      = to_q + TO_W'(1);

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    to_d       = to_q;
    err_d      = 1'b0;
    sent_d     = sent_q;
    sel_d      = sel_q;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          tx_data_d  = req_data[{gnt_idx, 3'b000} +: 8];
          grant_id_d = gnt_idx;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        to_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          to_d = to_inc;
          if (to_inc == TO_W'(BUSY_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          sent_d  = sent_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Track cfg_sel while idle and on the way back to idle, so a mid-frame change shows on the first idle cycle.
    if ((state_q == IDLE) || (state_d == IDLE)) begin
      sel_d = cfg_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      sel_q      <= '0;
      to_q       <= '0;
      err_q      <= 1'b0;
      sent_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      sel_q      <= sel_d;
      to_q       <= to_d;
      err_q      <= err_d;
      sent_q     <= sent_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// tb_uart_tx_sched: directed checks of launch timing, round-robin order, timeout, sel freeze, reset and counter wrap.
module tb_uart_tx_sched;
  import uart_sched_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int CNT_W        = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [1:0]           cfg_sel;
  logic [1:0]           sel;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [1:0]           grant_id;
  logic                 sched_busy;
  logic                 err_timeout;
  logic [CNT_W-1:0]     sent_cnt;

  logic busy_model = 1'b0;
  logic busy_force = 1'b0;
  logic auto_en    = 1'b1;
  assign tx_busy = busy_model | busy_force;

  uart_tx_sched #(
    .NUM_REQ      (NUM_REQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cfg_sel     (cfg_sel),
    .sel         (sel),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .err_timeout (err_timeout),
    .sent_cnt    (sent_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises 2 cycles after tx_start and stays high for 20 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && tx_start) begin
        @(posedge clk);
        @(posedge clk);
        #2 busy_model = 1'b1;
        repeat (20) @(posedge clk);
        #2 busy_model = 1'b0;
      end
    end
  end

  function automatic int idx_of(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  int         acc_cnt   = 0;
  int         start_cnt = 0;
  int         multi_hot = 0;
  int         data_bad  = 0;
  int         sel_bad   = 0;
  int         err_cnt   = 0;
  int         ts        = 0;
  int         te        = 0;
  logic [7:0] lat_data  = '0;
  logic [1:0] lat_sel   = '0;
  int         gnt_q[$];
  logic [7:0] data_q[$];

  always @(negedge clk) begin
    if ($countones(req_ready) > 1) multi_hot <= multi_hot + 1;
    if (|(req_ready & req_valid)) begin
      acc_cnt <= acc_cnt + 1;
      gnt_q.push_back(idx_of(req_ready));
    end
    if (tx_start) begin
      start_cnt <= start_cnt + 1;
      ts        <= cyc;
      lat_data  <= tx_data;
      lat_sel   <= sel;
      data_q.push_back(tx_data);
    end else if (sched_busy && reset) begin
      if (tx_data != lat_data) data_bad <= data_bad + 1;
      if (sel != lat_sel) sel_bad <= sel_bad + 1;
    end
    if (err_timeout) begin
      err_cnt <= err_cnt + 1;
      te      <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    nedge();
    while (sched_busy && n < 200) begin
      nedge();
      n++;
    end
    check_eq(tag, 32'(sched_busy), 0);
  endtask

  task automatic send(input int idx, input logic [7:0] data);
    int n = 0;
    tick();
    req_data[idx*8 +: 8] = data;
    req_valid[idx]       = 1'b1;
    nedge();
    while (!req_ready[idx] && n < 100) begin
      nedge();
      n++;
    end
    check_eq("accept_wait", 32'(req_ready[idx]), 1);
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int         n;
    int         base;
    int         err_base;
    logic [3:0] ready_or;
    logic [1:0] last_sel;

    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    cfg_sel   = 2'b11;
    repeat (3) nedge();
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_start", 32'(tx_start), 0);
    check_eq("rst_data", 32'(tx_data), 0);
    check_eq("rst_sel", 32'(sel), 0);
    check_eq("rst_grant", 32'(grant_id), 0);
    check_eq("rst_busy", 32'(sched_busy), 0);
    check_eq("rst_err", 32'(err_timeout), 0);
    check_eq("rst_cnt", 32'(sent_cnt), 0);
    cfg_sel = 2'b00;
    tick();
    reset = 1'b1;

    // Single request
    tick();
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    nedge();
    check_eq("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    nedge();
    check_eq("t1_start", 32'(tx_start), 1);
    check_eq("t1_data", 32'(tx_data), 32'hA5);
    check_eq("t1_grant", 32'(grant_id), 0);
    check_eq("t1_ready_off", 32'(req_ready), 0);
    wait_idle("t1_idle");
    check_eq("t1_cnt", 32'(sent_cnt), 1);
    check_eq("t1_accepts", acc_cnt, 1);
    check_eq("t1_starts", start_cnt, 1);
    check_eq("t1_data_hold", 32'(tx_data), 32'hA5);

    // Contention: all four valid continuously
    pulse_reset();
    gnt_q.delete();
    data_q.delete();
    tick();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    n = 0;
    nedge();
    while (gnt_q.size() < 5 && n < 500) begin
      nedge();
      n++;
    end
    tick();
    req_valid = '0;
    wait_idle("t2_idle");
    check_eq("t2_grants", gnt_q.size(), 5);
    for (int i = 0; i < 5 && i < gnt_q.size() && i < data_q.size(); i++) begin
      check_eq($sformatf("t2_grant%0d", i), gnt_q[i], i % 4);
      check_eq($sformatf("t2_data%0d", i), 32'(data_q[i]), 32'h10 + (i % 4));
    end
    check_eq("t2_multihot", multi_hot, 0);
    check_eq("t2_cnt", 32'(sent_cnt), 5);

    // Timeout: transmitter never goes busy
    auto_en  = 1'b0;
    base     = 32'(sent_cnt);
    err_base = err_cnt;
    send(2, 8'h5C);
    n = 0;
    while (!err_timeout && n < 40) begin
      nedge();
      n++;
    end
    check_eq("t3_err_seen", 32'(err_timeout), 1);
    check_eq("t3_err_delay", te - ts, BUSY_TIMEOUT + 1);
    check_eq("t3_idle", 32'(sched_busy), 0);
    check_eq("t3_cnt_hold", 32'(sent_cnt), base);
    nedge();
    check_eq("t3_err_pulse", err_cnt - err_base, 1);
    check_eq("t3_err_low", 32'(err_timeout), 0);
    auto_en = 1'b1;
    send(3, 8'h77);
    nedge();
    check_eq("t3_next_grant", 32'(grant_id), 3);
    check_eq("t3_next_data", 32'(tx_data), 32'h77);
    wait_idle("t3_idle2");
    check_eq("t3_next_cnt", 32'(sent_cnt), base + 1);

    // Sel freeze across a frame
    send(1, 8'h3C);
    n = 0;
    while (!tx_busy && n < 20) begin
      nedge();
      n++;
    end
    check_eq("t4_busy_seen", 32'(tx_busy), 1);
    tick();
    cfg_sel  = 2'b10;
    last_sel = sel;
    n = 0;
    nedge();
    while (sched_busy && n < 100) begin
      last_sel = sel;
      nedge();
      n++;
    end
    check_eq("t4_sel_frozen", 32'(last_sel), 0);
    check_eq("t4_sel_idle", 32'(sel), 32'h2);
    check_eq("t4_sel_bad", sel_bad, 0);

    // External busy while idle, then reset mid-frame
    tick();
    busy_force   = 1'b1;
    req_data[15:8] = 8'h42;
    req_valid[1] = 1'b1;
    ready_or     = '0;
    repeat (5) begin
      nedge();
      ready_or = ready_or | req_ready;
    end
    check_eq("t5_blocked", 32'(ready_or), 0);
    tick();
    busy_force = 1'b0;
    nedge();
    check_eq("t5_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    n = 0;
    nedge();
    while (!(tx_busy && sched_busy) && n < 20) begin
      nedge();
      n++;
    end
    check_eq("t5_in_frame", 32'(sched_busy), 1);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_ready", 32'(req_ready), 0);
    check_eq("t5_rst_start", 32'(tx_start), 0);
    check_eq("t5_rst_data", 32'(tx_data), 0);
    check_eq("t5_rst_sel", 32'(sel), 0);
    check_eq("t5_rst_grant", 32'(grant_id), 0);
    check_eq("t5_rst_busy", 32'(sched_busy), 0);
    check_eq("t5_rst_cnt", 32'(sent_cnt), 0);
    tick();
    tick();
    reset = 1'b1;
    n = 0;
    while (busy_model && n < 40) begin
      nedge();
      n++;
    end
    check_eq("t5_model_done", 32'(busy_model), 0);

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      send(i % 4, 8'(i));
      wait_idle("t6_idle");
    end
    check_eq("t6_wrap", 32'(sent_cnt), 1);
    check_eq("t6_data_bad", data_bad, 0);
    check_eq("t6_sel_bad", sel_bad, 0);
    check_eq("t6_multihot", multi_hot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
